xadc_scan_avg: RTL and testbench

// - Multi-channel successor to the single-channel XADC readout path; sits between the

---
 rtl/xadc_pkg.sv | 22 ++
 rtl/bar_encoder.sv | 15 +
 rtl/xadc_scan_avg.sv | 143 ++++++++++++++
 tb/tb_xadc_scan_avg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared constants for the XADC scan/average path: DRP channel addresses,
// result width and the read FSM state encoding.
package xadc_pkg;

   localparam int XADC_DATA_W = 12;

   localparam logic [6:0] VAUX2  = 7'h12;
   localparam logic [6:0] VAUX3  = 7'h13;
   localparam logic [6:0] VAUX10 = 7'h1a;
   localparam logic [6:0] VAUX11 = 7'h1b;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_READ_ENC = 2'd1;
   localparam logic [1:0] ST_WAIT_ENC = 2'd2;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE_ENC,
      READ      = ST_READ_ENC,
      WAIT_DRDY = ST_WAIT_ENC
   } state_t;

endpackage

// File: rtl/bar_encoder.sv
// 4-bit level to 16-LED thermometer: level n lights LEDs 0..n.
module bar_encoder (
   input  logic [3:0]  level,
   output logic [15:0] bar
);

   logic [16:0] one_hot;
   logic [16:0] filled;

   // One spare bit lets level 15 produce 0x10000, so the decrement fills all 16 LEDs.
   assign one_hot = 17'd1 << ({1'b0, level} + 5'd1);
   assign filled  = one_hot - 17'd1;
   assign bar     = filled[15:0];

endmodule

// File: rtl/xadc_scan_avg.sv
// Round-robin DRP reader for the XADC: one channel read per end-of-conversion,
// per-channel windowed averaging, tagged results and a bar graph for one channel.
module xadc_scan_avg
   import xadc_pkg::*;
#(
   parameter int                  NUM_CH       = 4,
   parameter logic [7*NUM_CH-1:0] CH_ADDR      = {VAUX11, VAUX10, VAUX3, VAUX2},
   parameter int                  AVG_LOG2     = 2,
   parameter int                  DRDY_TIMEOUT = 63,
   localparam int                 CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            eoc,
   input  logic            drdy,
   input  logic [15:0]     do_in,
   output logic            den,
   output logic [6:0]      daddr,
   output logic            sample_valid,
   output logic [CH_W-1:0] sample_ch,
   output logic [11:0]     sample_data,
   input  logic [CH_W-1:0] disp_sel,
   output logic [15:0]     bar,
   output logic            timeout_err
);

   localparam int ACC_W = XADC_DATA_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int TMR_W = $clog2(DRDY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [CH_W-1:0]  PTR_LAST = CH_W'(NUM_CH - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRDY_TIMEOUT - 1);

   state_t              state_reg, state_next;
   logic [CH_W-1:0]     ptr_reg;
   logic [TMR_W-1:0]    tmr_reg;
   logic [ACC_W-1:0]    acc_reg [NUM_CH];
   logic [CNT_W-1:0]    cnt_reg [NUM_CH];
   logic                sample_valid_reg;
   logic [CH_W-1:0]     sample_ch_reg;
   logic [11:0]         sample_data_reg;
   logic [15:0]         bar_reg;
   logic                timeout_err_reg;

   logic                accept;
   logic                expire;
   logic                window_done;
   logic [ACC_W-1:0]    acc_sum;
   logic [CH_W-1:0]     sel_eff;
   logic [15:0]         bar_level;
   logic [6:0]          addr_tbl [NUM_CH];
   logic                unused_low_bits;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_addr
      assign addr_tbl[gi] = CH_ADDR[7*gi +: 7];
   end

   // daddr follows ptr, which only moves when leaving WAIT_DRDY, so it is stable for the whole read.
   assign daddr           = addr_tbl[ptr_reg];
   assign acc_sum         = acc_reg[ptr_reg] + ACC_W'(do_in[15:4]);
   assign window_done     = accept && (cnt_reg[ptr_reg] == CNT_LAST);
   assign sel_eff         = (32'(disp_sel) < NUM_CH) ? disp_sel : '0;
   assign unused_low_bits = ^do_in[3:0];

   always_comb begin
      state_next = state_reg;
      den        = 1'b0;
      accept     = 1'b0;
      expire     = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (eoc) state_next = READ;
         end
         READ: begin
            den        = 1'b1;
            state_next = WAIT_DRDY;
         end
         WAIT_DRDY: begin
            if (drdy) begin
               accept     = 1'b1;
               state_next = IDLE;
            end else if (tmr_reg == TMR_LAST) begin
               expire     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         ptr_reg          <= '0;
         tmr_reg          <= '0;
         sample_valid_reg <= 1'b0;
         sample_ch_reg    <= '0;
         sample_data_reg  <= '0;
         bar_reg          <= 16'h0001;
         timeout_err_reg  <= 1'b0;
      end else begin
         state_reg        <= state_next;
         tmr_reg          <= (state_reg == WAIT_DRDY) ? tmr_reg + 1'b1 : '0;
         sample_valid_reg <= window_done;
         if (accept || expire) ptr_reg <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
         if (expire) timeout_err_reg <= 1'b1;
         if (window_done) begin
            sample_ch_reg   <= ptr_reg;
            sample_data_reg <= acc_sum[AVG_LOG2 +: XADC_DATA_W];
         end
         if (sample_valid_reg && (sample_ch_reg == sel_eff)) bar_reg <= bar_level;
      end
   end

   // A finished window clears its slot in the same edge that launches the result.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc_reg[i] <= '0;
            cnt_reg[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ptr_reg == CH_W'(i)) begin
               acc_reg[i] <= window_done ? '0 : acc_sum;
               cnt_reg[i] <= window_done ? '0 : cnt_reg[i] + 1'b1;
            end
         end
      end
   end

   bar_encoder u_bar_encoder (
      .level (sample_data_reg[11:8]),
      .bar   (bar_level)
   );

   assign sample_valid = sample_valid_reg;
   assign sample_ch    = sample_ch_reg;
   assign sample_data  = sample_data_reg;
   assign bar          = bar_reg;
   assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_xadc_scan_avg.sv
// Directed bench for xadc_scan_avg: table of round-robin reads plus hand-written
// sequences for dropped eoc, drdy timeout and reset in the middle of a read.
module tb_xadc_scan_avg;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        eoc = 1'b0;
   logic        drdy = 1'b0;
   logic [15:0] do_in = 16'h0;
   logic [1:0]  disp_sel = 2'd3;
   logic        den;
   logic [6:0]  daddr;
   logic        sample_valid;
   logic [1:0]  sample_ch;
   logic [11:0] sample_data;
   logic [15:0] bar;
   logic        timeout_err;

   xadc_scan_avg dut (
      .clock        (clock),
      .reset        (reset),
      .eoc          (eoc),
      .drdy         (drdy),
      .do_in        (do_in),
      .den          (den),
      .daddr        (daddr),
      .sample_valid (sample_valid),
      .sample_ch    (sample_ch),
      .sample_data  (sample_data),
      .disp_sel     (disp_sel),
      .bar          (bar),
      .timeout_err  (timeout_err)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int den_count = 0;
   int valid_count = 0;

   always @(negedge clock) begin
      if (den) den_count++;
      if (sample_valid) valid_count++;
   end

   typedef struct packed {
      logic [11:0] val;
      logic [6:0]  addr;
      logic        valid;
      logic [1:0]  ch;
      logic [11:0] data;
      logic [15:0] bar;
   } vec_t;

   vec_t        vecs [32];
   logic [6:0]  addr_of [4];
   logic [11:0] s1 [4][4];
   logic [11:0] s2 [4][4];
   logic [11:0] res1 [4];
   logic [11:0] res2 [4];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // One complete DRP transaction: eoc, den, drdy one cycle into WAIT_DRDY, then result and bar.
   task automatic rd(input logic [11:0] val, input logic [6:0] exp_addr, input logic exp_valid,
                     input logic [1:0] exp_ch, input logic [11:0] exp_data, input logic [15:0] exp_bar);
      string tag;
      tag = $sformatf("rd@%0h", exp_addr);
      eoc = 1'b1;
      @(posedge clock); #1 eoc = 1'b0;
      check({tag, " den"}, 32'(den), 32'd1);
      check({tag, " daddr"}, 32'(daddr), 32'(exp_addr));
      @(posedge clock); #1;
      check({tag, " den one cycle"}, 32'(den), 32'd0);
      drdy = 1'b1;
      do_in = {val, 4'h0};
      @(posedge clock); #1;
      drdy = 1'b0;
      do_in = 16'h0;
      check({tag, " sample_valid"}, 32'(sample_valid), 32'(exp_valid));
      if (exp_valid) begin
         check({tag, " sample_ch"}, 32'(sample_ch), 32'(exp_ch));
         check({tag, " sample_data"}, 32'(sample_data), 32'(exp_data));
      end
      @(posedge clock); #1;
      check({tag, " valid pulse"}, 32'(sample_valid), 32'd0);
      check({tag, " bar"}, 32'(bar), 32'(exp_bar));
      $display("[TB] read addr=%h val=%h valid=%b ch=%0d data=%h bar=%h",
               exp_addr, val, exp_valid, sample_ch, sample_data, bar);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int v0;
      int n;

      addr_of = '{7'h12, 7'h13, 7'h1a, 7'h1b};
      s1 = '{'{12'h100, 12'h200, 12'h300, 12'h400},
             '{12'h010, 12'h020, 12'h030, 12'h040},
             '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF},
             '{12'hF00, 12'hF00, 12'hF00, 12'hF04}};
      s2 = '{'{12'h001, 12'h002, 12'h003, 12'h005},
             '{12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF},
             '{12'h800, 12'h800, 12'h800, 12'h800},
             '{12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF}};
      res1 = '{12'h280, 12'h028, 12'hFFF, 12'hF01};
      res2 = '{12'h002, 12'h7FF, 12'h800, 12'h0FF};
      for (int r = 0; r < 32; r++) begin
         vecs[r].val   = (r >= 16) ? s2[r % 4][(r / 4) % 4] : s1[r % 4][(r / 4) % 4];
         vecs[r].addr  = addr_of[r % 4];
         vecs[r].valid = ((r / 4) % 4) == 3;
         vecs[r].ch    = 2'(r % 4);
         vecs[r].data  = (r >= 16) ? res2[r % 4] : res1[r % 4];
         vecs[r].bar   = (r >= 15 && r <= 30) ? 16'hFFFF : 16'h0001;
      end

      // Reset and idle
      repeat (3) @(posedge clock);
      #1;
      check("reset den", 32'(den), 32'd0);
      check("reset daddr", 32'(daddr), 32'h12);
      check("reset bar", 32'(bar), 32'h0001);
      reset = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      check("idle den count", 32'(den_count), 32'd0);
      check("idle valid count", 32'(valid_count), 32'd0);
      check("idle bar", 32'(bar), 32'h0001);
      check("idle timeout_err", 32'(timeout_err), 32'd0);
      check("idle sample_ch", 32'(sample_ch), 32'd0);
      check("idle sample_data", 32'(sample_data), 32'd0);

      // Two full averaging windows on all channels
      for (int r = 0; r < 32; r++)
         rd(vecs[r].val, vecs[r].addr, vecs[r].valid, vecs[r].ch, vecs[r].data, vecs[r].bar);

      // eoc two cycles after den is dropped
      d0 = den_count;
      eoc = 1'b1;
      @(posedge clock); #1 eoc = 1'b0;
      check("drop den", 32'(den), 32'd1);
      check("drop daddr", 32'(daddr), 32'h12);
      @(posedge clock); #1;
      @(posedge clock); #1 eoc = 1'b1;
      @(posedge clock); #1 eoc = 1'b0;
      drdy = 1'b1;
      do_in = {12'h123, 4'h0};
      @(posedge clock); #1;
      drdy = 1'b0;
      do_in = 16'h0;
      repeat (3) @(posedge clock);
      #1;
      check("drop den count", 32'(den_count - d0), 32'd1);
      rd(12'h204, 7'h13, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h000, 7'h1a, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h000, 7'h1b, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h123, 7'h12, 1'b0, 2'd0, 12'h000, 16'h0001);

      // ch1 read never answered
      d0 = den_count;
      eoc = 1'b1;
      @(posedge clock); #1 eoc = 1'b0;
      check("timeout daddr", 32'(daddr), 32'h13);
      check("timeout pre err", 32'(timeout_err), 32'd0);
      @(posedge clock); #1;
      n = 0;
      while (timeout_err !== 1'b1 && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check("timeout cycles", 32'(n), 32'd63);
      check("timeout_err set", 32'(timeout_err), 32'd1);
      check("timeout den count", 32'(den_count - d0), 32'd1);
      repeat (2) @(posedge clock);
      #1;
      rd(12'h000, 7'h1a, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h000, 7'h1b, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h100, 7'h12, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h200, 7'h13, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h000, 7'h1a, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h000, 7'h1b, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h100, 7'h12, 1'b1, 2'd0, 12'h111, 16'h0001);
      rd(12'h200, 7'h13, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h000, 7'h1a, 1'b1, 2'd2, 12'h000, 16'h0001);
      rd(12'h000, 7'h1b, 1'b1, 2'd3, 12'h000, 16'h0001);
      rd(12'h100, 7'h12, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h200, 7'h13, 1'b1, 2'd1, 12'h201, 16'h0001);
      check("timeout_err sticky", 32'(timeout_err), 32'd1);

      // Reset with two ch0 samples in the window and a read in flight
      rd(12'h000, 7'h1a, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'h000, 7'h1b, 1'b0, 2'd0, 12'h000, 16'h0001);
      rd(12'hF00, 7'h12, 1'b0, 2'd0, 12'h000, 16'h0001);
      eoc = 1'b1;
      @(posedge clock); #1 eoc = 1'b0;
      check("midreset den before", 32'(den), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("midreset den drop", 32'(den), 32'd0);
      @(posedge clock); #1 reset = 1'b0;
      v0 = valid_count;
      drdy = 1'b1;
      do_in = {12'hFFF, 4'h0};
      @(posedge clock); #1;
      drdy = 1'b0;
      do_in = 16'h0;
      @(posedge clock); #1;
      check("midreset stale drdy", 32'(valid_count - v0), 32'd0);
      check("midreset timeout_err", 32'(timeout_err), 32'd0);
      check("midreset daddr", 32'(daddr), 32'h12);
      check("midreset sample_data", 32'(sample_data), 32'd0);
      disp_sel = 2'd0;
      for (int r = 0; r < 13; r++)
         rd((r % 4 == 0) ? ((r == 12) ? 12'h104 : 12'h100) : 12'h000, addr_of[r % 4],
            r == 12, 2'd0, 12'h101, (r == 12) ? 16'h0003 : 16'h0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
